// File: rtl/gpu_bg_line_renderer_pkg.sv
// Shared constants for the background scanline renderer: VRAM map,
// FSM state encoding, nametable entry fields and derived widths.
// Optional feature macro used across this block: HSCROLL_EN.
package gpu_bg_line_renderer_pkg;

  localparam int DEF_NUM_COLS        = 32;
  localparam int DEF_NUM_ROWS        = 30;
  localparam int DEF_BPP             = 2;
  localparam int DEF_COLOR_WIDTH     = 3;
  localparam int DEF_VRAM_ADDR_WIDTH = 11;

  // VRAM write-side map
  localparam int PMB_BASE  = 'h000;
  localparam int PMB_SIZE  = 'h200;
  localparam int NTBL_BASE = 'h400;
  localparam int NTBL_SIZE = 'h400;

  // Nametable entry fields: [7] colour select, [6] hflip, [5] vflip, [4:0] pattern
  localparam int CSEL_BIT  = 7;
  localparam int HFLIP_BIT = 6;
  localparam int VFLIP_BIT = 5;

  // Colour-pair byte sits right after the visible nametable
  localparam int COLOR_BYTE_IDX = DEF_NUM_ROWS * DEF_NUM_COLS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_NT = 3'd1,
    ST_RD_HI = 3'd2,
    ST_RD_LO = 3'd3,
    ST_WR    = 3'd4
  } state_t;

  function automatic int color_byte_idx(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int pat_line_w(input int bpp);
    return 8 * bpp;
  endfunction

endpackage

// File: rtl/gpu_bg_line_renderer_if.sv
// Bus bundle for the background scanline renderer: VRAM write port,
// line control, pixel readout and debug visibility of the FSM.
// Handshake: cs qualifies one byte write per cycle (no back-pressure);
// line_start is a one-cycle request that is always accepted; line_done
// is a one-cycle completion pulse. scroll_x exists only with HSCROLL_EN.
interface gpu_bg_line_renderer_if
  import gpu_bg_line_renderer_pkg::*;
#(
  parameter int BPP             = DEF_BPP,
  parameter int COLOR_WIDTH     = DEF_COLOR_WIDTH,
  parameter int VRAM_ADDR_WIDTH = DEF_VRAM_ADDR_WIDTH
) ();

  logic [7:0]                 data;
  logic [VRAM_ADDR_WIDTH-1:0] address;
  logic                       cs;
  logic                       line_start;
  logic [7:0]                 line_y;
  logic [7:0]                 x;
`ifdef HSCROLL_EN
  logic [7:0]                 scroll_x;
`endif
  logic [BPP-1:0]             pix_idx;
  logic [COLOR_WIDTH-1:0]     pix_color;
  logic                       busy;
  logic                       line_done;
  logic                       overrun;
  state_t                     dbg_state;
  logic                       dbg_front;

`ifdef HSCROLL_EN
  modport master (
    output data, address, cs, line_start, line_y, x, scroll_x,
    input  pix_idx, pix_color, busy, line_done, overrun, dbg_state, dbg_front
  );
  modport slave (
    input  data, address, cs, line_start, line_y, x, scroll_x,
    output pix_idx, pix_color, busy, line_done, overrun, dbg_state, dbg_front
  );
`else
  modport master (
    output data, address, cs, line_start, line_y, x,
    input  pix_idx, pix_color, busy, line_done, overrun, dbg_state, dbg_front
  );
  modport slave (
    input  data, address, cs, line_start, line_y, x,
    output pix_idx, pix_color, busy, line_done, overrun, dbg_state, dbg_front
  );
`endif

endinterface

// File: rtl/gpu_bg_line_renderer_hflipper.sv
// Horizontal flip of one pattern line: reverses the order of the eight
// BPP-wide pixel fields while keeping each field's bits intact.
module pattern_hflipper_m #(
  parameter int BPP = 2
) (
  input  logic [8*BPP-1:0] line_i,
  input  logic             hflip_i,
  output logic [8*BPP-1:0] line_o
);

  logic [8*BPP-1:0] rev;

  // Field-wise reversal, selected by hflip
  always_comb begin
    rev = '0;
    for (int i = 0; i < 8; i++) begin
      rev[i*BPP +: BPP] = line_i[(7-i)*BPP +: BPP];
    end
    line_o = hflip_i ? rev : line_i;
  end

endmodule

// File: rtl/gpu_bg_line_renderer.sv
// Background scanline renderer. During blanking a 4-cycle-per-column FSM
// fetches nametable entries and pattern lines for the requested scanline
// and writes flipped, coloured pixels into the back half of a ping-pong
// line buffer; the pixel side reads the front half by x.
// Optional feature: define HSCROLL_EN to add a horizontal scroll offset.
module gpu_bg_line_renderer
  import gpu_bg_line_renderer_pkg::*;
#(
  parameter int NUM_COLS        = DEF_NUM_COLS,
  parameter int NUM_ROWS        = DEF_NUM_ROWS,
  parameter int BPP             = DEF_BPP,
  parameter int COLOR_WIDTH     = DEF_COLOR_WIDTH,
  parameter int VRAM_ADDR_WIDTH = DEF_VRAM_ADDR_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  gpu_bg_line_renderer_if.slave bus
);

  localparam int PAT_W    = pat_line_w(BPP);
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int PIX_W    = COL_W + 3;
  localparam int LINE_PIX = NUM_COLS * 8;
  localparam int WORD_W   = PAT_W + COLOR_WIDTH;
  localparam int PMB_AW   = $clog2(PMB_SIZE);
  localparam int NT_AW    = $clog2(NTBL_SIZE);
  localparam int PIDX_W   = PMB_AW - 4;
  localparam logic [NT_AW-1:0] CB_ADDR = NT_AW'(color_byte_idx(NUM_ROWS, NUM_COLS));

  // VRAM copies (simple dual-port, registered read returns pre-write data)
  logic [7:0]               pmb_mem [PMB_SIZE];
  logic [7:0]               nt_mem  [NTBL_SIZE];
  logic                     pmb_we, nt_we;
  logic [PMB_AW-1:0]        pmb_ra;
  logic [NT_AW-1:0]         nt_ra;
  logic [7:0]               pmb_rd_q, nt_rd_q;
  logic [2*COLOR_WIDTH-1:0] cb_rd_q;

  // FSM and control
  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic [2:0]       tile_y_q, tile_y_d;
  logic             front_q, front_d;
  logic             overrun_q, overrun_d;
  logic             line_done_q, line_done_d;
  logic             lb_we;

  // Per-column datapath
  logic [PIDX_W-1:0]      pat_q;
  logic                   hflip_q;
  logic [COLOR_WIDTH-1:0] color_q;
  logic [2:0]             vy_q, vy_now;
  logic [7:0]             hi_q;
  logic [PAT_W-1:0]       raw_line, flipped;
  logic                   blank_row;
  logic [WORD_W-1:0]      lb_wdata;

  // Line buffer: one word per column per bank, {colour, 8 pixel fields}
  logic [WORD_W-1:0] lbuf [2*NUM_COLS];

  // Readout
  logic [PIX_W-1:0]       rd_idx;
  logic [WORD_W-1:0]      rd_word;
  logic [PAT_W-1:0]       rd_shift;
  logic [BPP-1:0]         pix_idx_q;
  logic [COLOR_WIDTH-1:0] pix_color_q;
`ifdef HSCROLL_EN
  logic [7:0]             scroll_q;
`endif

  assign pmb_we = bus.cs && (int'(bus.address) >= PMB_BASE) &&
                  (int'(bus.address) < PMB_BASE + PMB_SIZE);
  assign nt_we  = bus.cs && (int'(bus.address) >= NTBL_BASE) &&
                  (int'(bus.address) < NTBL_BASE + NTBL_SIZE);

  // VRAM write and fetch-side reads
  always_ff @(posedge clk) begin
    if (pmb_we) pmb_mem[bus.address[PMB_AW-1:0]] <= bus.data;
    if (nt_we)  nt_mem[bus.address[NT_AW-1:0]]  <= bus.data;
    pmb_rd_q <= pmb_mem[pmb_ra];
    nt_rd_q  <= nt_mem[nt_ra];
    cb_rd_q  <= nt_mem[CB_ADDR][2*COLOR_WIDTH-1:0];
  end

  // Fetch addressing: hi byte straight from the fresh entry, lo byte from latched fields
  always_comb begin
    nt_ra  = NT_AW'({row_q, col_q});
    vy_now = nt_rd_q[VFLIP_BIT] ? (3'd7 - tile_y_q) : tile_y_q;
    if (state_q == ST_RD_HI) pmb_ra = {nt_rd_q[PIDX_W-1:0], vy_now, 1'b0};
    else                     pmb_ra = {pat_q, vy_q, 1'b1};
  end

  // FSM next state; line_start overrides everything (start or abort-restart)
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    tile_y_d    = tile_y_q;
    front_d     = front_q;
    overrun_d   = overrun_q;
    line_done_d = 1'b0;
    lb_we       = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_RD_NT: state_d = ST_RD_HI;
      ST_RD_HI: state_d = ST_RD_LO;
      ST_RD_LO: state_d = ST_WR;
      ST_WR: begin
        lb_we = 1'b1;
        if (col_q == COL_W'(NUM_COLS - 1)) begin
          state_d     = ST_IDLE;
          line_done_d = 1'b1;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = ST_RD_NT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.line_start) begin
      if (state_q == ST_IDLE) front_d   = ~front_q;
      else                    overrun_d = 1'b1;
      row_d       = bus.line_y[7:3];
      tile_y_d    = bus.line_y[2:0];
      col_d       = '0;
      state_d     = ST_RD_NT;
      line_done_d = 1'b0;
      lb_we       = 1'b0;
    end
  end

  // FSM and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      tile_y_q    <= '0;
      front_q     <= 1'b0;
      overrun_q   <= 1'b0;
      line_done_q <= 1'b0;
`ifdef HSCROLL_EN
      scroll_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      tile_y_q    <= tile_y_d;
      front_q     <= front_d;
      overrun_q   <= overrun_d;
      line_done_q <= line_done_d;
`ifdef HSCROLL_EN
      if (bus.line_start) scroll_q <= bus.scroll_x;
`endif
    end
  end

  // Latch entry fields, resolved colour and pattern hi byte as they arrive
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      hflip_q <= 1'b0;
      color_q <= '0;
      vy_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (state_q == ST_RD_HI) begin
        pat_q   <= nt_rd_q[PIDX_W-1:0];
        hflip_q <= nt_rd_q[HFLIP_BIT];
        color_q <= nt_rd_q[CSEL_BIT] ? cb_rd_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH]
                                     : cb_rd_q[COLOR_WIDTH-1:0];
        vy_q    <= vy_now;
      end
      if (state_q == ST_RD_LO) hi_q <= pmb_rd_q;
    end
  end

  assign raw_line  = {hi_q, pmb_rd_q};
  assign blank_row = int'(row_q) >= NUM_ROWS;
  assign lb_wdata  = {color_q, blank_row ? {PAT_W{1'b0}} : flipped};

  pattern_hflipper_m #(.BPP(BPP)) u_hflip (
    .line_i  (raw_line),
    .hflip_i (hflip_q),
    .line_o  (flipped)
  );

  // Back-buffer column write; reset clears both banks
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2*NUM_COLS; i++) lbuf[i] <= '0;
    end else if (lb_we) begin
      lbuf[{~front_q, col_q}] <= lb_wdata;
    end
  end

  // Front-buffer word select and pixel field alignment
  always_comb begin
`ifdef HSCROLL_EN
    rd_idx = PIX_W'(bus.x + scroll_q);
`else
    rd_idx = PIX_W'(bus.x);
`endif
    rd_word  = lbuf[{front_q, rd_idx[PIX_W-1:3]}];
    rd_shift = rd_word[PAT_W-1:0] << (BPP * int'(rd_idx[2:0]));
  end

  // Registered pixel output, blank beyond the line width (unscrolled x)
  always_ff @(posedge clk) begin
    if (rst || (int'(bus.x) >= LINE_PIX)) begin
      pix_idx_q   <= '0;
      pix_color_q <= '0;
    end else begin
      pix_idx_q   <= rd_shift[PAT_W-1 -: BPP];
      pix_color_q <= rd_word[WORD_W-1 -: COLOR_WIDTH];
    end
  end

  assign bus.pix_idx   = pix_idx_q;
  assign bus.pix_color = pix_color_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.line_done = line_done_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_front = front_q;

endmodule

// File: tb/tb_gpu_bg_line_renderer.sv
// Directed bench for gpu_bg_line_renderer: reset state, normal fetch,
// hflip, vflip, blank rows, last column, overrun and mid-fetch reset,
// plus horizontal scroll when HSCROLL_EN is defined.
module tb_gpu_bg_line_renderer;
  import gpu_bg_line_renderer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_front;
  logic [7:0] exp_q[$];

  gpu_bg_line_renderer_if #(.BPP(2), .COLOR_WIDTH(3), .VRAM_ADDR_WIDTH(11)) bus ();

  gpu_bg_line_renderer #(
    .NUM_COLS(32), .NUM_ROWS(30), .BPP(2), .COLOR_WIDTH(3), .VRAM_ADDR_WIDTH(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic vram_wr(input logic [10:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.address = a; bus.data = d;
    step();
    bus.cs = 1'b0;
  endtask

  task automatic start_line(input logic [7:0] y, input logic [7:0] sc);
    bus.line_start = 1'b1;
    bus.line_y     = y;
`ifdef HSCROLL_EN
    bus.scroll_x   = sc;
`else
    if (sc != 8'd0) $display("[TB] scroll ignored in this build");
`endif
    step();
    bus.line_start = 1'b0;
  endtask

  task automatic read_px(input logic [7:0] xv, output logic [1:0] idx, output logic [2:0] col);
    bus.x = xv;
    step();
    idx = bus.pix_idx;
    col = bus.pix_color;
  endtask

  // Reads consecutive pixels, pops expected indices from exp_q
  task automatic check_run(input string tag, input int base_x, input logic [2:0] col_exp);
    logic [1:0] idx;
    logic [2:0] col;
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      read_px(8'(base_x + i), idx, col);
      check($sformatf("%s_idx_x%0d", tag, base_x + i), {30'd0, idx}, {24'd0, exp_q.pop_front()});
      check($sformatf("%s_col_x%0d", tag, base_x + i), {29'd0, col}, {29'd0, col_exp});
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int early = 0;
    while (bus.busy && n < 300) begin
      if (bus.line_done) early++;
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, n, 128);
    check({tag, "_done"}, {31'd0, bus.line_done}, 1);
    check({tag, "_no_early_done"}, early, 0);
    step();
    check({tag, "_done_pulse"}, {31'd0, bus.line_done}, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 300) begin
      n++;
      step();
    end
    check({tag, "_idle"}, {31'd0, bus.busy}, 0);
    step();
  endtask

  initial begin
    logic [1:0] idx;
    logic [2:0] col;
    int dones;
    bus.cs = 1'b0; bus.address = '0; bus.data = '0;
    bus.line_start = 1'b0; bus.line_y = '0; bus.x = '0;
`ifdef HSCROLL_EN
    bus.scroll_x = '0;
`endif
    exp_front = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // 1: reset state
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_overrun", {31'd0, bus.overrun}, 0);
    check("rst_line_done", {31'd0, bus.line_done}, 0);
    check("rst_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    check("rst_front", {31'd0, bus.dbg_front}, 0);
    for (int xi = 0; xi < 256; xi++) begin
      read_px(8'(xi), idx, col);
      check("rst_pix_idx", {30'd0, idx}, 0);
      check("rst_pix_col", {29'd0, col}, 0);
    end

    // VRAM setup
    vram_wr(11'h400, 8'h81);
    for (int c = 1; c < 31; c++) vram_wr(11'(11'h400 + c), 8'h00);
    vram_wr(11'h41F, 8'h01);
    vram_wr(11'h7C0, 8'h2A);
    vram_wr(11'h016, 8'hE4);
    vram_wr(11'h017, 8'h00);
    vram_wr(11'h006, 8'h00);
    vram_wr(11'h007, 8'h00);
    vram_wr(11'h008, 8'h00);
    vram_wr(11'h009, 8'h00);
    vram_wr(11'h018, 8'hFF);
    vram_wr(11'h019, 8'hFF);
    vram_wr(11'h0A0, 8'hFF);
    vram_wr(11'h0A1, 8'hFF);
    // Unmapped addresses that would alias onto PMB/NTBL bytes if decoded loosely
    vram_wr(11'h216, 8'hFF);
    vram_wr(11'h3C0, 8'hFF);

    // 2: plain fetch
    start_line(8'd3, 8'd0); exp_front = ~exp_front;
    check("s2_front", {31'd0, bus.dbg_front}, {31'd0, exp_front});
    check("s2_busy", {31'd0, bus.busy}, 1);
    wait_done("s2");
    start_line(8'd3, 8'd0); exp_front = ~exp_front;
    check("s2b_front", {31'd0, bus.dbg_front}, {31'd0, exp_front});
    exp_q = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_run("s2", 0, 3'd5);
    exp_q = '{8'd0};
    check_run("s2_col1", 8, 3'd2);
    exp_q = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_run("s2_last", 248, 3'd2);
    wait_idle("s2b");

`ifdef HSCROLL_EN
    // 6: horizontal scroll
    start_line(8'd3, 8'd250); exp_front = ~exp_front;
    read_px(8'd10, idx, col);
    check("s6_x10_idx", {30'd0, idx}, 0);
    check("s6_x10_col", {29'd0, col}, 5);
    read_px(8'd6, idx, col);
    check("s6_x6_idx", {30'd0, idx}, 3);
    read_px(8'd7, idx, col);
    check("s6_x7_idx", {30'd0, idx}, 2);
    wait_idle("s6");
`endif

    // 3a: hflip
    vram_wr(11'h400, 8'hC1);
    start_line(8'd3, 8'd0); exp_front = ~exp_front;
    wait_done("s3h");
    start_line(8'd3, 8'd0); exp_front = ~exp_front;
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    check_run("s3h", 0, 3'd5);
    wait_idle("s3h_b");

    // 3b: vflip with line_y = 4 selects pattern line 3
    vram_wr(11'h400, 8'hA1);
    start_line(8'd4, 8'd0); exp_front = ~exp_front;
    wait_done("s3v");
    start_line(8'd4, 8'd0); exp_front = ~exp_front;
    exp_q = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_run("s3v", 0, 3'd5);
    exp_q = '{8'd3, 8'd3};
    check_run("s3v_last", 248, 3'd2);
    wait_idle("s3v_b");

    // Row beyond NUM_ROWS renders blank
    start_line(8'd240, 8'd0); exp_front = ~exp_front;
    wait_done("blank");
    start_line(8'd240, 8'd0); exp_front = ~exp_front;
    for (int xi = 0; xi < 8; xi++) begin
      read_px(8'(xi), idx, col);
      check("blank_idx", {30'd0, idx}, 0);
    end
    wait_idle("blank_b");

    // 4: overrun
    start_line(8'd3, 8'd0); exp_front = ~exp_front;
    check("s4_front1", {31'd0, bus.dbg_front}, {31'd0, exp_front});
    check("s4_overrun0", {31'd0, bus.overrun}, 0);
    repeat (49) step();
    start_line(8'd3, 8'd0);
    check("s4_front_held", {31'd0, bus.dbg_front}, {31'd0, exp_front});
    check("s4_overrun1", {31'd0, bus.overrun}, 1);
    check("s4_busy", {31'd0, bus.busy}, 1);
    wait_done("s4");
    check("s4_overrun_sticky", {31'd0, bus.overrun}, 1);

    // 5: reset mid-fetch
    start_line(8'd3, 8'd0); exp_front = ~exp_front;
    repeat (59) step();
    rst = 1'b1;
    step();
    exp_front = 1'b0;
    check("s5_busy", {31'd0, bus.busy}, 0);
    check("s5_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    check("s5_overrun", {31'd0, bus.overrun}, 0);
    check("s5_front", {31'd0, bus.dbg_front}, {31'd0, exp_front});
    check("s5_line_done", {31'd0, bus.line_done}, 0);
    check("s5_pix_idx", {30'd0, bus.pix_idx}, 0);
    check("s5_pix_col", {29'd0, bus.pix_color}, 0);
    rst = 1'b0;
    dones = 0;
    repeat (200) begin
      if (bus.line_done) dones++;
      step();
    end
    check("s5_no_done", dones, 0);
    check("s5_busy_after", {31'd0, bus.busy}, 0);
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0};
    check_run("s5_cleared", 0, 3'd0);
    exp_q = '{8'd0};
    check_run("s5_cleared_last", 255, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_bg_line_renderer.md
Name: gpu_bg_line_renderer

Overview:
Sequential successor to the parallel background path of gpu_m: renders one background scanline per line into a ping-pong line buffer instead of decoding all 32 columns combinationally.
- During blanking, an FSM walks NUM_COLS nametable entries for the requested scanline and fetches the pattern line.
- It applies vflip and hflip, resolves the 2-entry colour pair, and writes pixels to the back buffer.
- The pixel side reads the front buffer by x.
- Sits between the VRAM write port and the DVI colour mux.

Parameters:
NUM_COLS, 32, tile columns per line (power of 2)
NUM_ROWS, 30, tile rows; colour-pair byte sits at NTBL[NUM_ROWS*NUM_COLS]
BPP, 2, bits per pixel in a pattern line (pattern line = 8*BPP bits, stored as 2 bytes, high byte first)
COLOR_WIDTH, 3, width of each palette colour
VRAM_ADDR_WIDTH, 11, VRAM write address width

Ports:
clk  in  1  pixel clock (12.5875 MHz)
rst  in  1  reset; synchronous, active-high
data  in  8  VRAM write data
address  in  VRAM_ADDR_WIDTH  VRAM write address
cs  in  1  VRAM write strobe, one byte per cycle
line_start  in  1  one-cycle pulse: swap buffers, begin fetching line_y
line_y  in  8  scanline to render into back buffer, sampled with line_start
x  in  8  front-buffer pixel read index
pix_idx  out  BPP  pattern pixel value at x (0 = transparent)
pix_color  out  COLOR_WIDTH  tile colour for pixel at x
busy  out  1  fetch in progress
line_done  out  1  one-cycle pulse when the back buffer is complete
overrun  out  1  sticky: line_start arrived while busy

Behaviour:
- Memory map (write side):
  - 0x000-0x1FF: PMB (32 patterns x 16 bytes).
  - 0x400-0x7FF: NTBL.
  - Other addresses are ignored.
  - Internal memories are simple dual-port. A same-cycle read of a written address returns the old value.
- Reset state:
  - State IDLE; both buffers' colour and index cleared to 0.
  - Front select = 0.
  - busy = 0, line_done = 0, overrun = 0.
  - pix_idx = 0, pix_color = 0.
- line_start handling:
  - line_start in IDLE: toggle front select, latch row = line_y[7:3] and tile_y = line_y[2:0], set col = 0, busy = 1, go to RD_NT.
  - line_start while busy: abort the current fetch, set overrun, do NOT toggle front select, restart the fetch for the new line_y.
- FSM, 4 cycles per column:
  - RD_NT: read NTBL[row*NUM_COLS+col], and NTBL colour byte on a second read port.
  - RD_HI: latch entry; compute vy = vflip ? 7-tile_y : tile_y; read PMB[16*pmba+2*vy].
  - RD_LO: read PMB[16*pmba+2*vy+1].
  - WR: form the 16-bit line {hi, lo}; reverse the 8 pixel fields if hflip (fields stay intact, not a bit-reverse).
    - Write 8 pixels plus colour into back[col*8 +: 8]. Colour = entry[7] ? colour_byte[5:3] : colour_byte[2:0].
    - If col == NUM_COLS-1: go to IDLE, busy = 0, pulse line_done. Else col+1, go to RD_NT.
- Full line takes 4*NUM_COLS = 128 cycles; must fit in hblank (144 cycles).
- row >= NUM_ROWS: fetch still runs but forces pix_idx = 0 for all columns (blank line).
- Readout latency: pix_idx/pix_color are registered, 1 cycle after x. x >= NUM_COLS*8 returns 0/0.
- rst mid-fetch aborts to IDLE immediately; no line_done is emitted.
- VRAM writes during a fetch are legal. Bytes read before the write keep their old value.

Optional Feature:
HSCROLL_EN:
- Defined: adds input scroll_x[7:0]. It is sampled with line_start and held for the displayed line.
  - Readout index = (x + scroll_x) mod (NUM_COLS*8).
  - The x >= NUM_COLS*8 blanking check uses the unscrolled x.
- Undefined: no port; readout index = x.

Decomposition:
- Shared package/include: VRAM base addresses (PMB_BASE, NTBL_BASE), FSM state encodings, colour-byte index constant, pattern-line width derived from BPP.
- Reuse pattern_hflipper_m as the sole sub-module for the flip stage.
- Line buffers are inferred RAM inside this block.

Test Plan:
1. Reset, then read x = 0..255 -> pix_idx = 0, pix_color = 0, busy = 0, overrun = 0.
2. Write NTBL[0] = 0x81, PMB pattern 1 line 3 = 0xE400, colour byte = 0x2A (c0 = 2, c1 = 5); line_start with line_y = 3.
   - Expect line_done after 128 cycles.
   - Expect busy high for exactly 128 cycles.
   - After the next line_start, x = 0..7 -> idx 3,2,1,0,0,0,0,0 and colour 5.
3. Same setup with NTBL[0] = 0xC1 (hflip) -> idx 0,0,0,0,0,1,2,3.
   - With 0xA1 (vflip) and line_y = 4 -> line 3 is used, same pixels as scenario 2.
4. line_start, then a second line_start 50 cycles later -> overrun = 1, front select unchanged.
   - line_done arrives 128 cycles after the second pulse.
5. Assert rst at cycle 60 of a fetch -> busy = 0 the next cycle, no line_done, all outputs 0.
6. HSCROLL_EN with scroll_x = 250 -> x = 10 reads pixel 4.
   - With scroll_x = 0, x = 256 reads 0/0.
